// File: rtl/pq_pkg.sv
// Shared types for the priority-queue request controller: op encoding, FSM states and default widths.
package pq_pkg;

    localparam int unsigned TW_DEF = 4;
    localparam int unsigned PW_DEF = 4;

    typedef enum logic [1:0] {
        OP_ILL  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_DROP = 2'b11
    } pq_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } pq_state_e;

endpackage

// File: rtl/pq_timeout_cnt.sv
// Response timeout counter: cleared on issue, counts enabled WAIT cycles, flags the TO_CYC-th one.
module pq_timeout_cnt #(
    parameter int unsigned TO_CYC = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = (TO_CYC > 1) ? $clog2(TO_CYC + 1) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != CW'(TO_CYC))) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Flags the cycle whose increment brings the count to TO_CYC, so WAIT lasts exactly TO_CYC cycles.
    assign expired_o = en_i && (r_cnt == CW'(TO_CYC - 1));

endmodule

// File: rtl/pq_req_ctrl.sv
// Request controller in front of a systolic priority-queue array: one op outstanding, occupancy tracking, timeout.
module pq_req_ctrl
    import pq_pkg::*;
#(
    parameter int unsigned TW     = TW_DEF,
    parameter int unsigned PW     = PW_DEF,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TO_CYC = 15,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_vld_i,
    output logic            req_rdy_o,
    input  logic [1:0]      req_op_i,
    input  logic [TW-1:0]   req_id_i,
    input  logic [PW-1:0]   req_prio_i,
    output logic            rsp_vld_o,
    input  logic            rsp_rdy_i,
    output logic [TW-1:0]   rsp_id_o,
    output logic [PW-1:0]   rsp_prio_o,
    output logic            rsp_err_o,
    output logic            push_o,
    output logic            pop_o,
    output logic            drop_o,
    output logic [TW-1:0]   id_o,
    output logic [PW-1:0]   prio_o,
    output logic [TW-1:0]   drop_id_o,
    input  logic            push_vld_i,
    input  logic            pop_vld_i,
    input  logic            drop_vld_i,
    input  logic            drop_hit_i,
    input  logic [TW-1:0]   pop_id_i,
    input  logic [PW-1:0]   pop_prio_i,
    output logic [CW-1:0]   cnt_o,
    output logic            full_o,
    output logic            empty_o,
    output pq_state_e       dbg_state_o
);

    pq_state_e     r_state;
    pq_op_e        r_op;
    logic [TW-1:0] r_id;
    logic [PW-1:0] r_prio;
    logic [TW-1:0] r_rsp_id;
    logic [PW-1:0] r_rsp_prio;
    logic          r_rsp_err;
    logic [CW-1:0] r_cnt;

    pq_op_e        w_op;
    logic          w_full;
    logic          w_empty;
    logic          w_reject;
    logic          w_done;
    logic          w_expired;

    assign w_op    = pq_op_e'(req_op_i);
    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_empty = (r_cnt == '0);

    // Requests that can never succeed are answered straight away without touching the array.
    assign w_reject = (w_op == OP_ILL)
                   || ((w_op == OP_PUSH) && (w_full || (req_id_i == '0)))
                   || ((w_op == OP_POP) && w_empty)
                   || ((w_op == OP_DROP) && (w_empty || (req_id_i == '0)));

    assign w_done = ((r_op == OP_PUSH) && push_vld_i)
                 || ((r_op == OP_POP) && pop_vld_i)
                 || ((r_op == OP_DROP) && drop_vld_i);

    pq_timeout_cnt #(.TO_CYC(TO_CYC)) u_tmo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (r_state == ST_ISSUE),
        .en_i      (r_state == ST_WAIT),
        .expired_o (w_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_ILL;
            r_id       <= '0;
            r_prio     <= '0;
            r_rsp_id   <= '0;
            r_rsp_prio <= '0;
            r_rsp_err  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_vld_i) begin
                        r_op       <= w_op;
                        r_id       <= req_id_i;
                        r_prio     <= req_prio_i;
                        r_rsp_id   <= (w_op == OP_POP) ? '0 : req_id_i;
                        r_rsp_prio <= (w_op == OP_POP) ? '0 : req_prio_i;
                        r_rsp_err  <= w_reject;
                        r_state    <= w_reject ? ST_RESP : ST_ISSUE;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (w_done) begin
                        r_state <= ST_RESP;
                        case (r_op)
                            OP_PUSH: begin
                                if (w_full) r_rsp_err <= 1'b1;
                                else        r_cnt     <= r_cnt + CW'(1);
                            end
                            OP_POP: begin
                                if (w_empty) begin
                                    r_rsp_err <= 1'b1;
                                end else begin
                                    r_cnt      <= r_cnt - CW'(1);
                                    r_rsp_id   <= pop_id_i;
                                    r_rsp_prio <= pop_prio_i;
                                end
                            end
                            OP_DROP: begin
                                if (!drop_hit_i || w_empty) r_rsp_err <= 1'b1;
                                else                        r_cnt     <= r_cnt - CW'(1);
                            end
                            default: r_rsp_err <= 1'b1;
                        endcase
                    end else if (w_expired) begin
                        r_rsp_err <= 1'b1;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_rdy_i) begin
                        r_rsp_err <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Handshake: a request transfers on req_vld_i & req_rdy_o, a response on rsp_vld_o & rsp_rdy_i;
    // a valid side holds its payload unchanged until the transfer.
    assign req_rdy_o   = (r_state == ST_IDLE);
    assign rsp_vld_o   = (r_state == ST_RESP);
    assign rsp_id_o    = r_rsp_id;
    assign rsp_prio_o  = r_rsp_prio;
    assign rsp_err_o   = r_rsp_err;
    assign push_o      = (r_state == ST_ISSUE) && (r_op == OP_PUSH);
    assign pop_o       = (r_state == ST_ISSUE) && (r_op == OP_POP);
    assign drop_o      = (r_state == ST_ISSUE) && (r_op == OP_DROP);
    assign id_o        = r_id;
    assign prio_o      = r_prio;
    assign drop_id_o   = r_id;
    assign cnt_o       = r_cnt;
    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pq_req_ctrl.sv
// Bench for pq_req_ctrl: directed vector table, reset-abandon sequence, randomized requests against an occupancy model.
module tb_pq_req_ctrl;
  import pq_pkg::*;

  localparam int TW     = 4;
  localparam int PW     = 4;
  localparam int DEPTH  = 8;
  localparam int TO_CYC = 15;
  localparam int CW     = $clog2(DEPTH + 1);

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            req_vld_i;
  logic            req_rdy_o;
  logic [1:0]      req_op_i;
  logic [TW-1:0]   req_id_i;
  logic [PW-1:0]   req_prio_i;
  logic            rsp_vld_o;
  logic            rsp_rdy_i;
  logic [TW-1:0]   rsp_id_o;
  logic [PW-1:0]   rsp_prio_o;
  logic            rsp_err_o;
  logic            push_o, pop_o, drop_o;
  logic [TW-1:0]   id_o;
  logic [PW-1:0]   prio_o;
  logic [TW-1:0]   drop_id_o;
  logic            push_vld_i, pop_vld_i, drop_vld_i, drop_hit_i;
  logic [TW-1:0]   pop_id_i;
  logic [PW-1:0]   pop_prio_i;
  logic [CW-1:0]   cnt_o;
  logic            full_o, empty_o;
  pq_state_e       dbg_state_o;

  pq_req_ctrl #(.TW(TW), .PW(PW), .DEPTH(DEPTH), .TO_CYC(TO_CYC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_op_i(req_op_i),
    .req_id_i(req_id_i), .req_prio_i(req_prio_i),
    .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i), .rsp_id_o(rsp_id_o),
    .rsp_prio_o(rsp_prio_o), .rsp_err_o(rsp_err_o),
    .push_o(push_o), .pop_o(pop_o), .drop_o(drop_o),
    .id_o(id_o), .prio_o(prio_o), .drop_id_o(drop_id_o),
    .push_vld_i(push_vld_i), .pop_vld_i(pop_vld_i), .drop_vld_i(drop_vld_i),
    .drop_hit_i(drop_hit_i), .pop_id_i(pop_id_i), .pop_prio_i(pop_prio_i),
    .cnt_o(cnt_o), .full_o(full_o), .empty_o(empty_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [TW-1:0] id;
    logic [PW-1:0] prio;
    int            dly;     // completion delay after strobe, -1 = array never answers
    logic          hit;
    logic [TW-1:0] pid;
    logic [PW-1:0] pprio;
    int            stall;   // cycles rsp_rdy_i is held low
    logic          noise;   // pulse the non-matching completions once
    logic          e_err;
    logic [TW-1:0] e_id;
    logic [PW-1:0] e_prio;
    int            e_cnt;
    int            e_lat;
    int            e_str;
  } vec_t;

  function automatic vec_t mk(input int op, input int id, input int prio, input int dly,
                              input int hit, input int pid, input int pprio, input int stall,
                              input int noise, input int e_err, input int e_id, input int e_prio,
                              input int e_cnt, input int e_lat, input int e_str);
    vec_t v;
    v.op = 2'(op); v.id = TW'(id); v.prio = PW'(prio); v.dly = dly; v.hit = 1'(hit);
    v.pid = TW'(pid); v.pprio = PW'(pprio); v.stall = stall; v.noise = 1'(noise);
    v.e_err = 1'(e_err); v.e_id = TW'(e_id); v.e_prio = PW'(e_prio);
    v.e_cnt = e_cnt; v.e_lat = e_lat; v.e_str = e_str;
    return v;
  endfunction

  // Reference: decides the outcome from the request rules and the current occupancy.
  function automatic vec_t model(input vec_t v, input int cnt);
    bit rej;
    rej = (v.op == 2'd0)
       || (v.op == 2'd1 && (v.id == 0 || cnt == DEPTH))
       || (v.op == 2'd2 && cnt == 0)
       || (v.op == 2'd3 && (v.id == 0 || cnt == 0));
    v.e_id   = (v.op == 2'd2) ? '0 : v.id;
    v.e_prio = (v.op == 2'd2) ? '0 : v.prio;
    v.e_cnt  = cnt;
    v.e_err  = 1'b1;
    if (rej) begin
      v.e_lat = 1;
      v.e_str = 0;
    end else begin
      v.e_str = 1;
      if (v.dly < 0) begin
        v.e_lat = 2 + TO_CYC;
      end else begin
        v.e_lat = 2 + v.dly;
        if (v.op == 2'd1) begin
          v.e_err = 1'b0; v.e_cnt = cnt + 1;
        end else if (v.op == 2'd2) begin
          v.e_err = 1'b0; v.e_cnt = cnt - 1; v.e_id = v.pid; v.e_prio = v.pprio;
        end else if (v.hit) begin
          v.e_err = 1'b0; v.e_cnt = cnt - 1;
        end
      end
    end
    return v;
  endfunction

  // driver: one full request/response transaction with a behavioural array answering the strobe
  task automatic run_vec(input vec_t v, input string tag);
    int lat, st_at, n_str, n_match;
    logic [TW-1:0] h_id;
    logic [PW-1:0] h_prio;
    logic h_err;
    chk({tag, "_rdy"}, 32'(req_rdy_o), 32'd1);
    req_vld_i = 1'b1; req_op_i = v.op; req_id_i = v.id; req_prio_i = v.prio;
    @(negedge clk_i);
    req_vld_i = 1'b0; req_op_i = 2'd0; req_id_i = '0; req_prio_i = '0;
    lat = -1; st_at = -1; n_str = 0; n_match = 0;
    for (int cyc = 1; cyc < 40; cyc++) begin
      push_vld_i = 1'b0; pop_vld_i = 1'b0; drop_vld_i = 1'b0; drop_hit_i = 1'b0;
      if (rsp_vld_o) begin
        lat = cyc;
        break;
      end
      if (push_o || pop_o || drop_o) begin
        st_at = cyc;
        n_str += int'(push_o) + int'(pop_o) + int'(drop_o);
        if ((v.op == 2'd1 && push_o) || (v.op == 2'd2 && pop_o) || (v.op == 2'd3 && drop_o)) n_match++;
        if (v.op == 2'd1) begin
          chk({tag, "_id_o"}, 32'(id_o), 32'(v.id));
          chk({tag, "_prio_o"}, 32'(prio_o), 32'(v.prio));
        end
        if (v.op == 2'd3) chk({tag, "_drop_id_o"}, 32'(drop_id_o), 32'(v.id));
      end
      if (st_at > 0 && v.noise && v.dly != 1 && cyc == st_at + 1) begin
        push_vld_i = (v.op != 2'd1); pop_vld_i = (v.op != 2'd2); drop_vld_i = (v.op != 2'd3);
        drop_hit_i = 1'b1;
      end
      if (st_at > 0 && v.dly > 0 && cyc == st_at + v.dly) begin
        push_vld_i = (v.op == 2'd1); pop_vld_i = (v.op == 2'd2); drop_vld_i = (v.op == 2'd3);
        drop_hit_i = v.hit; pop_id_i = v.pid; pop_prio_i = v.pprio;
      end
      @(negedge clk_i);
    end
    push_vld_i = 1'b0; pop_vld_i = 1'b0; drop_vld_i = 1'b0; drop_hit_i = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(v.e_lat));
    chk({tag, "_strobes"}, 32'(n_str), 32'(v.e_str));
    chk({tag, "_strobe_kind"}, 32'(n_match), 32'(v.e_str));
    if (lat > 0) begin
      h_id = rsp_id_o; h_prio = rsp_prio_o; h_err = rsp_err_o;
      chk({tag, "_rsp_err"}, 32'(h_err), 32'(v.e_err));
      chk({tag, "_rsp_id"}, 32'(h_id), 32'(v.e_id));
      chk({tag, "_rsp_prio"}, 32'(h_prio), 32'(v.e_prio));
      for (int s = 0; s < v.stall; s++) begin
        @(negedge clk_i);
        chk({tag, "_hold_vld"}, 32'(rsp_vld_o), 32'd1);
        chk({tag, "_hold_id"}, 32'(rsp_id_o), 32'(h_id));
        chk({tag, "_hold_prio"}, 32'(rsp_prio_o), 32'(h_prio));
        chk({tag, "_hold_err"}, 32'(rsp_err_o), 32'(h_err));
      end
      rsp_rdy_i = 1'b1;
      @(negedge clk_i);
      rsp_rdy_i = 1'b0;
      chk({tag, "_rsp_done"}, 32'(rsp_vld_o), 32'd0);
      chk({tag, "_idle"}, 32'(dbg_state_o), 32'(ST_IDLE));
    end
    chk({tag, "_cnt"}, 32'(cnt_o), 32'(v.e_cnt));
    chk({tag, "_full"}, 32'(full_o), 32'(v.e_cnt == DEPTH));
    chk({tag, "_empty"}, 32'(empty_o), 32'(v.e_cnt == 0));
  endtask

  vec_t tbl[$];
  vec_t rv;
  int   m_cnt;

  initial begin
    rst_ni = 1'b1;
    req_vld_i = 1'b0; req_op_i = '0; req_id_i = '0; req_prio_i = '0; rsp_rdy_i = 1'b0;
    push_vld_i = 1'b0; pop_vld_i = 1'b0; drop_vld_i = 1'b0; drop_hit_i = 1'b0;
    pop_id_i = '0; pop_prio_i = '0;
    #1 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);

    chk("rst_cnt", 32'(cnt_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_strobes", 32'({push_o, pop_o, drop_o}), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld_o), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("rst_data", 32'({rsp_id_o, rsp_prio_o, id_o, prio_o, drop_id_o}), 32'd0);
    chk("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
    rst_ni = 1'b1;
    @(negedge clk_i);

    //      op id pr dly hit pid pp stl nz | err eid epr cnt lat str
    tbl.push_back(mk(1, 3, 5, 2, 0, 0, 0, 0, 1,   0, 3, 5, 1, 4, 1));
    tbl.push_back(mk(2, 0, 0, 1, 0, 3, 5, 0, 0,   0, 3, 5, 0, 3, 1));
    tbl.push_back(mk(2, 0, 0, 1, 0, 3, 5, 0, 0,   1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 2, 1, 1, 0, 0, 0, 0, 0,   1, 2, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 6, 1, 0, 0, 0, 0, 0,   1, 0, 6, 0, 1, 0));
    tbl.push_back(mk(3, 7, 0, 1, 1, 0, 0, 0, 0,   1, 7, 0, 0, 1, 0));
    for (int i = 0; i < DEPTH; i++)
      tbl.push_back(mk(1, i + 1, i, 1 + (i % 3), 0, 0, 0, 0, 1, 0, i + 1, i, i + 1, 3 + (i % 3), 1));
    tbl.push_back(mk(1, 9, 1, 1, 0, 0, 0, 0, 0,   1, 9, 1, 8, 1, 0));
    tbl.push_back(mk(3, 7, 0, 1, 0, 0, 0, 0, 0,   1, 7, 0, 8, 3, 1));
    tbl.push_back(mk(3, 7, 0, 3, 1, 0, 0, 0, 1,   0, 7, 0, 7, 5, 1));
    tbl.push_back(mk(1, 4, 2, -1, 0, 0, 0, 4, 0,  1, 4, 2, 7, 2 + TO_CYC, 1));
    tbl.push_back(mk(2, 0, 0, 1, 0, 12, 9, 2, 1,  0, 12, 9, 6, 3, 1));
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while a push is outstanding, then a stray completion while idle.
    req_vld_i = 1'b1; req_op_i = 2'd1; req_id_i = 4'd5; req_prio_i = 4'd1;
    @(negedge clk_i);
    req_vld_i = 1'b0; req_op_i = '0; req_id_i = '0; req_prio_i = '0;
    chk("abandon_push_o", 32'(push_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("abandon_push_cleared", 32'(push_o), 32'd0);
    chk("abandon_state", 32'(dbg_state_o), 32'(ST_IDLE));
    chk("abandon_cnt", 32'(cnt_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    push_vld_i = 1'b1;
    @(negedge clk_i);
    push_vld_i = 1'b0;
    chk("stray_cnt", 32'(cnt_o), 32'd0);
    chk("stray_rsp_vld", 32'(rsp_vld_o), 32'd0);
    chk("stray_rdy", 32'(req_rdy_o), 32'd1);
    @(negedge clk_i);
    chk("stray_state", 32'(dbg_state_o), 32'(ST_IDLE));

    m_cnt = 0;
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      rv.op    = (r == 0) ? 2'd0 : (r <= 4) ? 2'd1 : (r <= 7) ? 2'd2 : 2'd3;
      rv.id    = TW'($urandom_range(0, 15));
      rv.prio  = PW'($urandom_range(0, 15));
      rv.dly   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 4));
      rv.hit   = 1'($urandom_range(0, 1));
      rv.pid   = TW'($urandom_range(1, 15));
      rv.pprio = PW'($urandom_range(0, 15));
      rv.stall = int'($urandom_range(0, 2));
      rv.noise = 1'($urandom_range(0, 1));
      rv = model(rv, m_cnt);
      m_cnt = rv.e_cnt;
      run_vec(rv, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pq_req_ctrl.md
PQ_REQ_CTRL -- requirements
Module: pq_req_ctrl

Interface
REQ-001 Parameter TW, default 4: task ID width; ID 0 means "no task/empty".
REQ-002 Parameter PW, default 4: priority width.
REQ-003 Parameter DEPTH, default 8: number of cells in the array.
REQ-004 Parameter TO_CYC, default 15: response timeout in cycles.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 req_vld_i  in  1  client request valid.
REQ-008 req_rdy_o  out  1  controller can accept a request.
REQ-009 req_op_i  in  2  01 push, 10 pop, 11 drop, 00 illegal.
REQ-010 req_id_i / req_prio_i  in  TW / PW  task ID and priority of the request.
REQ-011 rsp_vld_o / rsp_rdy_i  out / in  1 / 1  response handshake.
REQ-012 rsp_id_o / rsp_prio_o  out  TW / PW  popped task (pop), request ID echo (push/drop).
REQ-013 rsp_err_o  out  1  request rejected or timed out.
REQ-014 push_o, pop_o, drop_o  out  1 each  single-cycle operation strobes to the array head cell.
REQ-015 id_o / prio_o / drop_id_o  out  TW / PW / TW  operand buses to the array, stable from strobe until response.
REQ-016 push_vld_i, pop_vld_i, drop_vld_i  in  1 each  completion pulses from the array.
REQ-017 drop_hit_i  in  1  qualifies drop_vld_i: the ID was found and removed.
REQ-018 pop_id_i / pop_prio_i  in  TW / PW  head-cell data, sampled on pop_vld_i.
REQ-019 cnt_o  out  $clog2(DEPTH+1)  occupancy; full_o / empty_o  out  1  cnt_o==DEPTH / cnt_o==0.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: req_rdy_o=1; acceptance on req_vld_i&req_rdy_o registers op, ID, priority and moves to ISSUE; req_rdy_o=0 in all other states.
REQ-022 Rejection at acceptance: push with full_o, pop or drop with empty_o, op 00, or push/drop with ID 0 -> go directly to RESP with rsp_err_o=1; no strobe is issued.
REQ-023 ISSUE: assert exactly one of push_o/pop_o/drop_o for exactly one cycle; go to WAIT; clear the timeout counter.
REQ-024 WAIT: completion matches the issued op (push_vld_i / pop_vld_i / drop_vld_i); non-matching completion pulses are ignored; completion -> RESP.
REQ-025 Completion in the cycle directly after ISSUE is legal.
REQ-026 Timeout: counter increments each WAIT cycle; when it reaches TO_CYC without completion -> RESP with rsp_err_o=1; cnt_o unchanged.
REQ-027 On completion: push -> cnt_o+1; pop -> cnt_o-1 and latch pop_id_i/pop_prio_i into rsp_id_o/rsp_prio_o; drop -> cnt_o-1 only if drop_hit_i; otherwise rsp_err_o=1.
REQ-028 cnt_o saturates at 0 and at DEPTH; an update that would violate a bound is discarded and sets rsp_err_o.
REQ-029 RESP: rsp_vld_o=1 with data held stable until rsp_rdy_i; on handshake go to IDLE. Request-to-response minimum latency is 3 cycles.
REQ-030 Only one operation is outstanding at any time.

Reset
REQ-031 Asynchronous reset: state IDLE; cnt_o=0, empty_o=1, full_o=0; all strobes, rsp_vld_o and rsp_err_o 0; data outputs 0; timeout counter 0.
REQ-032 Reset mid-operation abandons the outstanding op; completion pulses arriving after reset release while in IDLE are ignored.

Structure
REQ-033 Shared package pq_pkg SHALL hold the op encoding enum and the default TW/PW constants.
REQ-034 Timeout counter SHALL be a sub-module pq_timeout_cnt (clear, enable, expired).

Verification
REQ-035 Reset, push ID 3 prio 5 with push_vld_i 2 cycles after push_o -> push_o pulses 1 cycle, rsp_vld_o with rsp_id_o=3, rsp_err_o=0, cnt_o=1.
REQ-036 Pop from count 1 with pop_vld_i, pop_id_i=3, pop_prio_i=5 -> rsp_id_o=3, rsp_prio_o=5, cnt_o=0, empty_o=1.
REQ-037 Pop while empty -> no pop_o strobe, rsp_err_o=1 within 2 cycles of acceptance.
REQ-038 DEPTH=8, 8 pushes then a 9th push -> full_o=1, 9th push gets rsp_err_o=1, cnt_o stays 8.
REQ-039 Drop ID 7 with drop_vld_i=1 and drop_hit_i=0 -> rsp_err_o=1, cnt_o unchanged; a retry with drop_hit_i=1 -> cnt_o decrements.
REQ-040 Push with no push_vld_i -> rsp_err_o=1 after 15 WAIT cycles, cnt_o unchanged; rsp_rdy_i held 0 for 4 cycles -> response stays stable.
